// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between CHANNELS requesting masters (instruction CMU,
// data CMU, DMA, debug, ...) using the cs/we/addr/data/ack handshake on both
// sides. One transaction is in flight at a time:
//   IDLE -> BUSY (request latched) -> DONE (one-cycle ack) -> IDLE.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   ch_cs_i       : per-channel request
//   ch_we_i       : per-channel write enable
//   ch_addr_i     : packed per-channel address, channel k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   ch_data_i     : packed per-channel write data, same packing
//   ch_data_o     : shared read-data register
//   ch_ack_o      : one-hot, one-cycle completion pulse
//   ch_err_o      : completion was caused by a timeout (valid with ch_ack_o)
//   mem_cs_o/mem_we_o/mem_addr_o/mem_data_o : registered memory request
//   mem_data_i/mem_ack_i                    : memory read data / completion
//   grant_o       : one-hot owner of the memory port, 0 when idle
//   busy_o        : waiting on the memory
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int CHANNELS   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RR_MODE    = 1,
    parameter int TIMEOUT    = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            ch_cs_i,
    input  logic [CHANNELS-1:0]            ch_we_i,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] ch_addr_i,
    input  logic [CHANNELS*DATA_WIDTH-1:0] ch_data_i,
    output logic [DATA_WIDTH-1:0]          ch_data_o,
    output logic [CHANNELS-1:0]            ch_ack_o,
    output logic                           ch_err_o,
    output logic                           mem_cs_o,
    output logic                           mem_we_o,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    output logic [DATA_WIDTH-1:0]          mem_data_o,
    input  logic [DATA_WIDTH-1:0]          mem_data_i,
    input  logic                           mem_ack_i,
    output logic [CHANNELS-1:0]            grant_o,
    output logic                           busy_o
);
    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state,    w_state_next;
    logic [PTR_W-1:0]      r_ptr,      w_ptr_next;
    logic [CNT_W-1:0]      r_cnt,      w_cnt_next;
    logic [CHANNELS-1:0]   r_grant,    w_grant_next;
    logic [CHANNELS-1:0]   r_ack,      w_ack_next;
    logic                  r_err,      w_err_next;
    logic [DATA_WIDTH-1:0] r_data,     w_data_next;
    logic                  r_mem_cs,   w_mem_cs_next;
    logic                  r_mem_we,   w_mem_we_next;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_next;
    logic [DATA_WIDTH-1:0] r_mem_data, w_mem_data_next;
    logic                  r_busy,     w_busy_next;

    logic [ADDR_WIDTH-1:0] w_ch_addr [CHANNELS];
    logic [DATA_WIDTH-1:0] w_ch_data [CHANNELS];
    logic [PTR_W-1:0]      w_win;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign w_ch_addr[gi] = ch_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_ch_data[gi] = ch_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin scans ptr+1, ptr+2, ... (mod CHANNELS), so the channel served
    // last has the lowest priority. Fixed priority scans 0, 1, 2, ...
    function automatic logic [PTR_W-1:0] pick_winner(input logic [CHANNELS-1:0] req,
                                                     input logic [PTR_W-1:0]    ptr);
        logic [PTR_W-1:0] win;
        logic             found;
        int               idx;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            if (RR_MODE != 0) begin
                idx = (int'(ptr) + i) % CHANNELS;
            end else begin
                idx = i - 1;
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = idx[PTR_W-1:0];
            end
        end
        return win;
    endfunction

    assign w_win = pick_winner(ch_cs_i, r_ptr);

    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_cnt_next      = r_cnt;
        w_grant_next    = r_grant;
        w_ack_next      = r_ack;
        w_err_next      = r_err;
        w_data_next     = r_data;
        w_mem_cs_next   = r_mem_cs;
        w_mem_we_next   = r_mem_we;
        w_mem_addr_next = r_mem_addr;
        w_mem_data_next = r_mem_data;
        w_busy_next     = r_busy;

        case (r_state)
            S_IDLE: begin
                if (|ch_cs_i) begin
                    w_state_next    = S_BUSY;
                    w_ptr_next      = w_win;
                    w_cnt_next      = '0;
                    w_grant_next    = CHANNELS'(1) << w_win;
                    w_mem_cs_next   = 1'b1;
                    w_mem_we_next   = ch_we_i[w_win];
                    w_mem_addr_next = w_ch_addr[w_win];
                    w_mem_data_next = w_ch_data[w_win];
                    w_busy_next     = 1'b1;
                end
            end
            S_BUSY: begin
                if (mem_ack_i) begin
                    if (!r_mem_we) begin
                        w_data_next = mem_data_i;
                    end
                    w_ack_next    = r_grant;
                    w_err_next    = 1'b0;
                    w_mem_cs_next = 1'b0;
                    w_mem_we_next = 1'b0;
                    w_busy_next   = 1'b0;
                    w_state_next  = S_DONE;
                end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
                    // Abort: complete towards the requester with the error flag,
                    // leaving the read-data register untouched.
                    w_ack_next    = r_grant;
                    w_err_next    = 1'b1;
                    w_mem_cs_next = 1'b0;
                    w_mem_we_next = 1'b0;
                    w_busy_next   = 1'b0;
                    w_state_next  = S_DONE;
                end else if (r_cnt != '1) begin
                    // Saturating: with the timeout disabled the counter just parks.
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_ack_next   = '0;
                w_err_next   = 1'b0;
                w_grant_next = '0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= PTR_RESET;
            r_cnt      <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_data     <= '0;
            r_mem_cs   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_cnt      <= w_cnt_next;
            r_grant    <= w_grant_next;
            r_ack      <= w_ack_next;
            r_err      <= w_err_next;
            r_data     <= w_data_next;
            r_mem_cs   <= w_mem_cs_next;
            r_mem_we   <= w_mem_we_next;
            r_mem_addr <= w_mem_addr_next;
            r_mem_data <= w_mem_data_next;
            r_busy     <= w_busy_next;
        end
    end

    assign ch_data_o  = r_data;
    assign ch_ack_o   = r_ack;
    assign ch_err_o   = r_err;
    assign mem_cs_o   = r_mem_cs;
    assign mem_we_o   = r_mem_we;
    assign mem_addr_o = r_mem_addr;
    assign mem_data_o = r_mem_data;
    assign grant_o    = r_grant;
    assign busy_o     = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiters with three channels each: index 0 is round-robin with a
// 4-cycle timeout, index 1 is fixed priority without timeout. A transaction-
// level reference model predicts every output each cycle; directed sequences
// pin the model with literal expectations, then randomized traffic follows.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Stimulus, per DUT
    logic [N-1:0]    cs   [2];
    logic [N-1:0]    we   [2];
    logic [N*AW-1:0] addr [2];
    logic [N*DW-1:0] wd   [2];
    logic [DW-1:0]   mdat [2];
    logic            mack [2];

    // DUT outputs
    logic [DW-1:0] o_data  [2];
    logic [N-1:0]  o_ack   [2];
    logic          o_err   [2];
    logic          o_mcs   [2];
    logic          o_mwe   [2];
    logic [AW-1:0] o_maddr [2];
    logic [DW-1:0] o_mwd   [2];
    logic [N-1:0]  o_grant [2];
    logic          o_busy  [2];

    // Model expectations
    logic [DW-1:0] e_data  [2];
    logic [N-1:0]  e_ack   [2];
    logic          e_err   [2];
    logic          e_mcs   [2];
    logic          e_mwe   [2];
    logic [AW-1:0] e_maddr [2];
    logic [DW-1:0] e_mwd   [2];
    logic [N-1:0]  e_grant [2];
    logic          e_busy  [2];
    int            own     [2];
    int            waited  [2];
    int            last    [2];

    int  n_vec  = 0;
    int  n_miss = 0;
    bit  rand_on = 1'b0;

    mem_arbiter #(.CHANNELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1), .TIMEOUT(4)) u_rr (
        .clk(clk), .rst(rst),
        .ch_cs_i(cs[0]), .ch_we_i(we[0]), .ch_addr_i(addr[0]), .ch_data_i(wd[0]),
        .ch_data_o(o_data[0]), .ch_ack_o(o_ack[0]), .ch_err_o(o_err[0]),
        .mem_cs_o(o_mcs[0]), .mem_we_o(o_mwe[0]), .mem_addr_o(o_maddr[0]), .mem_data_o(o_mwd[0]),
        .mem_data_i(mdat[0]), .mem_ack_i(mack[0]),
        .grant_o(o_grant[0]), .busy_o(o_busy[0])
    );

    mem_arbiter #(.CHANNELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0), .TIMEOUT(0)) u_fp (
        .clk(clk), .rst(rst),
        .ch_cs_i(cs[1]), .ch_we_i(we[1]), .ch_addr_i(addr[1]), .ch_data_i(wd[1]),
        .ch_data_o(o_data[1]), .ch_ack_o(o_ack[1]), .ch_err_o(o_err[1]),
        .mem_cs_o(o_mcs[1]), .mem_we_o(o_mwe[1]), .mem_addr_o(o_maddr[1]), .mem_data_o(o_mwd[1]),
        .mem_data_i(mdat[1]), .mem_ack_i(mack[1]),
        .grant_o(o_grant[1]), .busy_o(o_busy[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        e_data[d]  = '0;  e_ack[d]   = '0;  e_err[d]  = 1'b0;
        e_mcs[d]   = 1'b0; e_mwe[d]  = 1'b0; e_maddr[d] = '0;
        e_mwd[d]   = '0;  e_grant[d] = '0;  e_busy[d] = 1'b0;
        own[d]     = -1;  waited[d]  = 0;   last[d]   = N - 1;
    endtask

    // One clock edge of behaviour for DUT d, from the inputs held across the edge.
    task automatic model_step(input int d);
        int limit;
        bit rr;
        int g;
        int c;
        limit = (d == 0) ? 4 : 0;
        rr    = (d == 0);
        if (rst) begin
            model_reset(d);
            return;
        end
        if (e_ack[d] != 0) begin
            // completion pulse has been seen for one cycle: release the port
            e_ack[d]   = '0;
            e_err[d]   = 1'b0;
            e_grant[d] = '0;
            own[d]     = -1;
        end else if (!e_busy[d]) begin
            g = -1;
            for (int i = 1; i <= N; i++) begin
                c = rr ? (last[d] + i) % N : i - 1;
                if (g < 0 && cs[d][c]) g = c;
            end
            if (g >= 0) begin
                own[d]     = g;
                if (rr) last[d] = g;
                e_grant[d] = N'(1) << g;
                e_mcs[d]   = 1'b1;
                e_mwe[d]   = we[d][g];
                e_maddr[d] = addr[d][g*AW +: AW];
                e_mwd[d]   = wd[d][g*DW +: DW];
                e_busy[d]  = 1'b1;
                waited[d]  = 0;
            end
        end else if (mack[d] || (limit != 0 && waited[d] == limit - 1)) begin
            if (mack[d] && !e_mwe[d]) e_data[d] = mdat[d];
            e_err[d]  = !mack[d];
            e_ack[d]  = N'(1) << own[d];
            e_mcs[d]  = 1'b0;
            e_mwe[d]  = 1'b0;
            e_busy[d] = 1'b0;
        end else begin
            waited[d]++;
        end
    endtask

    task automatic compare(input int d);
        chk($sformatf("dut%0d grant_o", d),    64'(o_grant[d]), 64'(e_grant[d]));
        chk($sformatf("dut%0d ch_ack_o", d),   64'(o_ack[d]),   64'(e_ack[d]));
        chk($sformatf("dut%0d ch_err_o", d),   64'(o_err[d]),   64'(e_err[d]));
        chk($sformatf("dut%0d ch_data_o", d),  64'(o_data[d]),  64'(e_data[d]));
        chk($sformatf("dut%0d mem_cs_o", d),   64'(o_mcs[d]),   64'(e_mcs[d]));
        chk($sformatf("dut%0d mem_we_o", d),   64'(o_mwe[d]),   64'(e_mwe[d]));
        chk($sformatf("dut%0d mem_addr_o", d), 64'(o_maddr[d]), 64'(e_maddr[d]));
        chk($sformatf("dut%0d mem_data_o", d), 64'(o_mwd[d]),   64'(e_mwd[d]));
        chk($sformatf("dut%0d busy_o", d),     64'(o_busy[d]),  64'(e_busy[d]));
    endtask

    // Advance one clock; model and DUT both step at the edge, compare 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_step(d);
        #1;
        for (int d = 0; d < 2; d++) compare(d);
    endtask

    task automatic rand_stim();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N; k++) begin
                if (cs[d][k]) begin
                    if (o_ack[d][k]) cs[d][k] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    cs[d][k]            = 1'b1;
                    we[d][k]            = 1'($urandom_range(1));
                    addr[d][k*AW +: AW] = $urandom;
                    wd[d][k*DW +: DW]   = $urandom;
                end
            end
            mack[d] = ($urandom_range(3) == 0);
            mdat[d] = $urandom;
        end
    endtask

    initial begin
        int n;
        int lastk;
        for (int d = 0; d < 2; d++) begin
            cs[d] = '0; we[d] = '0; addr[d] = '0; wd[d] = '0; mdat[d] = '0; mack[d] = 1'b0;
            model_reset(d);
        end
        rst = 1'b1;
        cycle();
        cycle();
        #3 rst = 1'b0;
        chk("reset grant_o",   64'(o_grant[0]), 64'h0);
        chk("reset mem_cs_o",  64'(o_mcs[0]),   64'h0);
        chk("reset ch_data_o", 64'(o_data[0]),  64'h0);

        // Single read on channel 0, memory acks on the third BUSY cycle
        cs[0] = 3'b001;
        addr[0][0 +: AW] = 32'h10;
        cycle();
        chk("read mem_cs_o",   64'(o_mcs[0]),   64'h1);
        chk("read mem_addr_o", 64'(o_maddr[0]), 64'h10);
        cycle();
        cycle();
        chk("read mem_cs_o third cycle", 64'(o_mcs[0]), 64'h1);
        mack[0] = 1'b1;
        mdat[0] = 32'hDEADBEEF;
        cycle();
        chk("read ch_ack_o",    64'(o_ack[0]),  64'h1);
        chk("read ch_data_o",   64'(o_data[0]), 64'hDEADBEEF);
        chk("read mem_cs_o off",64'(o_mcs[0]),  64'h0);
        chk("read grant held",  64'(o_grant[0]),64'h1);
        cs[0] = '0; mack[0] = 1'b0; mdat[0] = '0;
        cycle();
        chk("read grant_o released", 64'(o_grant[0]), 64'h0);

        // Write on channel 1
        cs[0] = 3'b010; we[0] = 3'b010;
        addr[0][AW +: AW] = 32'h24;
        wd[0][DW +: DW]   = 32'h12345678;
        cycle();
        chk("write mem_we_o",   64'(o_mwe[0]),   64'h1);
        chk("write mem_data_o", 64'(o_mwd[0]),   64'h12345678);
        chk("write mem_addr_o", 64'(o_maddr[0]), 64'h24);
        mack[0] = 1'b1; mdat[0] = 32'hCAFEF00D;
        cycle();
        chk("write ch_ack_o",       64'(o_ack[0]),  64'h2);
        chk("write ch_data_o holds",64'(o_data[0]), 64'hDEADBEEF);
        cs[0] = '0; we[0] = '0; mack[0] = 1'b0;
        cycle();

        // Timeout: memory never answers
        cs[0] = 3'b001;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (o_mcs[0]) n++;
            if (o_ack[0] != 0) break;
        end
        chk("timeout mem_cs_o cycles", 64'(n), 64'd4);
        chk("timeout ch_ack_o", 64'(o_ack[0]), 64'h1);
        chk("timeout ch_err_o", 64'(o_err[0]), 64'h1);
        cs[0] = '0;
        cycle();

        // Asynchronous reset in the middle of a BUSY transaction
        cs[0] = 3'b001;
        cycle();
        cycle();
        #3 rst = 1'b1;
        #1;
        chk("midrst mem_cs_o",  64'(o_mcs[0]),   64'h0);
        chk("midrst busy_o",    64'(o_busy[0]),  64'h0);
        chk("midrst grant_o",   64'(o_grant[0]), 64'h0);
        chk("midrst ch_ack_o",  64'(o_ack[0]),   64'h0);
        chk("midrst ch_data_o", 64'(o_data[0]),  64'h0);
        model_reset(0);
        model_reset(1);
        cs[0] = 3'b011;
        cs[1] = 3'b011;
        cycle();
        #3 rst = 1'b0;

        // Channels 0 and 1 requesting continuously with a zero-wait memory
        n = 0;
        lastk = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            for (int d = 0; d < 2; d++) mack[d] = o_mcs[d];
            cycle();
            if (o_ack[0] != 0) begin
                chk("rr grant order", 64'(o_ack[0]), (n % 2 == 0) ? 64'h1 : 64'h2);
                if (n > 0) chk("rr turnaround cycles", 64'(k - lastk), 64'd3);
                lastk = k;
                n++;
            end
            if (o_ack[1] != 0) chk("fixed priority ack", 64'(o_ack[1]), 64'h1);
            for (int d = 0; d < 2; d++) cs[d] = 3'b011 & ~o_ack[d];
        end
        chk("rr transactions completed", 64'(n), 64'd4);

        // Randomized traffic
        rand_on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rand_stim();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
